// File: rtl/encryption_i1_pkg.sv
// Shared definitions for the nonce-exchange initiator.
//   state_t : controller states IDLE -> EXP -> SEND -> WAIT -> CHECK
//   DW_DEF  : default modulus / exponent width
//   NW_DEF  : default nonce / ciphertext width
package encryption_i1_pkg;

    localparam int unsigned DW_DEF = 32;
    localparam int unsigned NW_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        EXP,
        SEND,
        WAIT,
        CHECK
    } state_t;

endpackage

// File: rtl/encryption_i1_if.sv
// Controller and nonce-link signals of the initiator.
//   master : key-exchange controller / responder side (drives start, p, x, r2, r1, c2, c2_valid)
//   slave  : initiator side (drives c1, c1_valid, busy, done, true, err)
interface encryption_i1_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned NW = 4
) ();

    logic          start;
    logic [DW-1:0] p;
    logic [DW-1:0] x;
    logic [NW-1:0] r2;
    logic [NW-1:0] r1;
    logic [NW-1:0] c2;
    logic          c2_valid;
    logic [NW-1:0] c1;
    logic          c1_valid;
    logic          busy;
    logic          done;
    logic          true;
    logic          err;

    modport master (
        output start, p, x, r2, r1, c2, c2_valid,
        input  c1, c1_valid, busy, done, true, err
    );

    modport slave (
        input  start, p, x, r2, r1, c2, c2_valid,
        output c1, c1_valid, busy, done, true, err
    );

endinterface

// File: rtl/encryption_i1_mod_mul.sv
// Combinational modular multiply r = (a * b) % p at DW width.
//   a, b : operands (DW)
//   p    : modulus (DW), caller guarantees p >= 2 whenever r is used
//   r    : result (DW)
module encryption_i1_mod_mul
    import encryption_i1_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] p,
    output logic [DW-1:0] r
);

    logic [2*DW-1:0] prod;

    // Full 2*DW-bit product so no bits are lost before the reduction.
    assign prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    assign r    = DW'(prod % {{DW{1'b0}}, p});

endmodule

// File: rtl/encryption_i1.sv
// Initiator of the nonce-exchange handshake.
// Computes k = r2^x mod p (square-and-multiply, MSB first), sends
// c1 = k[NW-1:0] ^ r2, waits for c2 and checks k[NW-1:0] ^ c2 == r1.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of encryption_i1_if
//              in : start, p, x, r2, r1, c2, c2_valid
//              out: c1, c1_valid (pulse), busy, done (pulse), true, err
module encryption_i1
    import encryption_i1_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned NW     = NW_DEF,
    parameter int unsigned TO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    encryption_i1_if.slave bus
);

    localparam int unsigned IW = $clog2(DW);
    localparam int unsigned CW = $clog2(TO_CYC + 1);

    state_t        state;
    logic [DW-1:0] p_q;
    logic [DW-1:0] x_q;
    logic [NW-1:0] r2_q;
    logic [NW-1:0] r1_q;
    logic [DW-1:0] acc;
    logic [DW-1:0] base;
    logic [IW-1:0] idx;
    logic          mul_phase;
    logic [CW-1:0] cnt;
    logic [DW-1:0] mm_b;
    logic [DW-1:0] mm_r;

    // Square phase multiplies acc by itself, multiply phase by base.
    assign mm_b = mul_phase ? base : acc;

    encryption_i1_mod_mul #(.DW(DW)) u_mod_mul (
        .a (acc),
        .b (mm_b),
        .p (p_q),
        .r (mm_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            p_q          <= '0;
            x_q          <= '0;
            r2_q         <= '0;
            r1_q         <= '0;
            acc          <= '0;
            base         <= '0;
            idx          <= '0;
            mul_phase    <= 1'b0;
            cnt          <= '0;
            bus.c1       <= '0;
            bus.c1_valid <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.true     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.c1_valid <= 1'b0;
            bus.done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        p_q      <= bus.p;
                        x_q      <= bus.x;
                        r2_q     <= bus.r2;
                        r1_q     <= bus.r1;
                        bus.c1   <= '0;
                        bus.true <= 1'b0;
                        bus.busy <= 1'b1;
                        if (bus.p < DW'(2)) begin
                            // Degenerate modulus: report straight away, no c1.
                            bus.err  <= 1'b1;
                            bus.done <= 1'b1;
                            state    <= CHECK;
                        end else begin
                            bus.err   <= 1'b0;
                            acc       <= DW'(1);
                            base      <= DW'(bus.r2) % bus.p;
                            idx       <= IW'(DW - 1);
                            mul_phase <= 1'b0;
                            state     <= EXP;
                        end
                    end
                end
                EXP: begin
                    if (!mul_phase) begin
                        acc       <= mm_r;
                        mul_phase <= 1'b1;
                    end else begin
                        if (x_q[idx]) begin
                            acc <= mm_r;
                        end
                        mul_phase <= 1'b0;
                        if (idx == '0) begin
                            state <= SEND;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end
                SEND: begin
                    bus.c1       <= acc[NW-1:0] ^ r2_q;
                    bus.c1_valid <= 1'b1;
                    cnt          <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    // done/true/err are registered on entry to CHECK so they
                    // coincide with the CHECK cycle; c2_valid has priority.
                    if (bus.c2_valid) begin
                        bus.true <= ((acc[NW-1:0] ^ bus.c2) == r1_q);
                        bus.done <= 1'b1;
                        state    <= CHECK;
                    end else if (cnt == CW'(TO_CYC)) begin
                        bus.err  <= 1'b1;
                        bus.done <= 1'b1;
                        state    <= CHECK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHECK: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
